// File: rtl/exc_sequencer_pkg.sv
// Shared definitions for the precise-exception sequencer: cause codes, vector
// layout, Status bit positions, FSM encoding and capture/output payloads.
package exc_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned EXC_W = 5;
  localparam int unsigned INT_W = 6;

  localparam logic [XLEN-1:0] RESET_VECTOR    = 32'hBFC0_0000;
  localparam logic [XLEN-1:0] EBASE           = 32'h8000_0000;
  localparam logic [XLEN-1:0] VEC_OFS_REFILL  = 32'h0000_0000;
  localparam logic [XLEN-1:0] VEC_OFS_GENERAL = 32'h0000_0180;
  localparam logic [XLEN-1:0] VEC_OFS_BEV     = 32'h0000_0200;

  localparam int unsigned SR_IE     = 0;
  localparam int unsigned SR_EXL    = 1;
  localparam int unsigned SR_IM_LO  = 8;
  localparam int unsigned SR_IM_HW  = 10;
  localparam int unsigned SR_IM_HI  = 15;
  localparam int unsigned SR_BEV    = 22;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_MOD  = 5'd1;
  localparam logic [EXC_W-1:0] EXC_TLBL = 5'd2;
  localparam logic [EXC_W-1:0] EXC_TLBS = 5'd3;
  localparam logic [EXC_W-1:0] EXC_ADEL = 5'd4;
  localparam logic [EXC_W-1:0] EXC_ADES = 5'd5;
  localparam logic [EXC_W-1:0] EXC_SYS  = 5'd8;
  localparam logic [EXC_W-1:0] EXC_BP   = 5'd9;
  localparam logic [EXC_W-1:0] EXC_RI   = 5'd10;
  localparam logic [EXC_W-1:0] EXC_OV   = 5'd12;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMMIT    = 2'd1,
    ST_REDIRECT  = 2'd2,
    ST_ERET_WAIT = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic adel_if;
    logic tlbl_refill;
    logic tlbl_inv;
    logic ri;
    logic sys;
    logic bp;
    logic ov;
    logic adel;
    logic ades;
    logic tlbs_refill;
    logic tlbs_inv;
    logic tlb_mod;
  } exc_flags_t;

  typedef struct packed {
    logic [EXC_W-1:0] exccode;
    logic [XLEN-1:0]  epc;
    logic             bd;
    logic [XLEN-1:0]  badvaddr;
    logic             badvaddr_valid;
    logic [XLEN-1:0]  target;
  } exc_capture_t;

  typedef struct packed {
    logic             stall;
    logic             flush;
    logic             redirect_valid;
    logic [XLEN-1:0]  redirect_pc;
    logic             cp0_we;
    logic [XLEN-1:0]  cp0_epc;
    logic [EXC_W-1:0] cp0_exccode;
    logic             cp0_bd;
    logic             cp0_badvaddr_we;
    logic [XLEN-1:0]  cp0_badvaddr;
    logic             cp0_exl_set;
    logic             cp0_exl_clr;
  } seq_out_t;

  // Refill uses the dedicated offset only when entered from user/kernel (EXL=0).
  function automatic logic [XLEN-1:0] vector_target(input logic bev, input logic refill_fast);
    logic [XLEN-1:0] base;
    base = bev ? (RESET_VECTOR + VEC_OFS_BEV) : EBASE;
    return base + (refill_fast ? VEC_OFS_REFILL : VEC_OFS_GENERAL);
  endfunction

endpackage

// File: rtl/exc_sequencer_if.sv
// Pipeline/CP0/fetch bundle around the exception sequencer; slave is the
// sequencer side, master is the core side.
interface exc_sequencer_if;
  import exc_sequencer_pkg::*;

  logic              mem_valid_i;
  logic [XLEN-1:0]   mem_pc_i;
  logic              mem_bd_i;
  logic [INT_W-1:0]  interrupt_i;
  logic              exc_adel_if_i;
  logic              exc_tlbl_refill_i;
  logic              exc_tlbl_inv_i;
  logic              exc_ri_i;
  logic              exc_sys_i;
  logic              exc_bp_i;
  logic              exc_ov_i;
  logic              exc_adel_i;
  logic              exc_ades_i;
  logic              exc_tlbs_refill_i;
  logic              exc_tlbs_inv_i;
  logic              exc_tlb_mod_i;
  logic              eret_i;
  logic [XLEN-1:0]   bad_vaddr_i;
  logic [XLEN-1:0]   cp0_status_i;
  logic [XLEN-1:0]   cp0_epc_i;
  logic              redirect_ready_i;

  logic              stall_o;
  logic              flush_o;
  logic              redirect_valid_o;
  logic [XLEN-1:0]   redirect_pc_o;
  logic              cp0_we_o;
  logic [XLEN-1:0]   cp0_epc_o;
  logic [EXC_W-1:0]  cp0_exccode_o;
  logic              cp0_bd_o;
  logic              cp0_badvaddr_we_o;
  logic [XLEN-1:0]   cp0_badvaddr_o;
  logic              cp0_exl_set_o;
  logic              cp0_exl_clr_o;

  modport slave (
    input  mem_valid_i, mem_pc_i, mem_bd_i, interrupt_i,
           exc_adel_if_i, exc_tlbl_refill_i, exc_tlbl_inv_i, exc_ri_i, exc_sys_i,
           exc_bp_i, exc_ov_i, exc_adel_i, exc_ades_i, exc_tlbs_refill_i,
           exc_tlbs_inv_i, exc_tlb_mod_i, eret_i, bad_vaddr_i, cp0_status_i,
           cp0_epc_i, redirect_ready_i,
    output stall_o, flush_o, redirect_valid_o, redirect_pc_o, cp0_we_o, cp0_epc_o,
           cp0_exccode_o, cp0_bd_o, cp0_badvaddr_we_o, cp0_badvaddr_o,
           cp0_exl_set_o, cp0_exl_clr_o
  );

  modport master (
    output mem_valid_i, mem_pc_i, mem_bd_i, interrupt_i,
           exc_adel_if_i, exc_tlbl_refill_i, exc_tlbl_inv_i, exc_ri_i, exc_sys_i,
           exc_bp_i, exc_ov_i, exc_adel_i, exc_ades_i, exc_tlbs_refill_i,
           exc_tlbs_inv_i, exc_tlb_mod_i, eret_i, bad_vaddr_i, cp0_status_i,
           cp0_epc_i, redirect_ready_i,
    input  stall_o, flush_o, redirect_valid_o, redirect_pc_o, cp0_we_o, cp0_epc_o,
           cp0_exccode_o, cp0_bd_o, cp0_badvaddr_we_o, cp0_badvaddr_o,
           cp0_exl_set_o, cp0_exl_clr_o
  );

endinterface

// File: rtl/exc_prio_enc.sv
// Combinational cause priority encoder: picks the highest-priority pending
// cause and reports its ExcCode and whether BadVAddr / refill vector apply.
module exc_prio_enc
  import exc_sequencer_pkg::*;
(
  input  logic             int_pend,
  input  exc_flags_t       flags,
  output logic             any,
  output logic [EXC_W-1:0] exccode,
  output logic             badvaddr_valid,
  output logic             is_refill
);

  always_comb begin
    any            = 1'b1;
    exccode        = EXC_INT;
    badvaddr_valid = 1'b0;
    is_refill      = 1'b0;
    if (int_pend) begin
      exccode = EXC_INT;
    end else if (flags.adel_if) begin
      exccode = EXC_ADEL;  badvaddr_valid = 1'b1;
    end else if (flags.tlbl_refill) begin
      exccode = EXC_TLBL;  badvaddr_valid = 1'b1;  is_refill = 1'b1;
    end else if (flags.tlbl_inv) begin
      exccode = EXC_TLBL;  badvaddr_valid = 1'b1;
    end else if (flags.ri) begin
      exccode = EXC_RI;
    end else if (flags.sys) begin
      exccode = EXC_SYS;
    end else if (flags.bp) begin
      exccode = EXC_BP;
    end else if (flags.ov) begin
      exccode = EXC_OV;
    end else if (flags.adel) begin
      exccode = EXC_ADEL;  badvaddr_valid = 1'b1;
    end else if (flags.ades) begin
      exccode = EXC_ADES;  badvaddr_valid = 1'b1;
    end else if (flags.tlbs_refill) begin
      exccode = EXC_TLBS;  badvaddr_valid = 1'b1;  is_refill = 1'b1;
    end else if (flags.tlbs_inv) begin
      exccode = EXC_TLBS;  badvaddr_valid = 1'b1;
    end else if (flags.tlb_mod) begin
      exccode = EXC_MOD;   badvaddr_valid = 1'b1;
    end else begin
      any = 1'b0;
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Precise-exception / ERET sequencer: captures the winning MEM-stage cause,
// commits CP0 state, flushes and stalls the pipe and redirects fetch.
module exc_sequencer
  import exc_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  exc_sequencer_if.slave    bus
);

  logic [INT_W-1:0] int_meta;
  logic [INT_W-1:0] int_sync;

  seq_state_e   state_q, state_d;
  exc_capture_t cap_q, cap_d;
  seq_out_t     out_q, out_d;

  logic             int_pend;
  exc_flags_t       flags;
  logic             enc_any;
  logic [EXC_W-1:0] enc_code;
  logic             enc_bv_valid;
  logic             enc_refill;

  logic             sr_ie;
  logic             sr_exl;
  logic             sr_bev;
  logic [INT_W-1:0] sr_im_hw;
  logic             unused_status;

  assign sr_ie         = bus.cp0_status_i[SR_IE];
  assign sr_exl        = bus.cp0_status_i[SR_EXL];
  assign sr_bev        = bus.cp0_status_i[SR_BEV];
  assign sr_im_hw      = bus.cp0_status_i[SR_IM_HI:SR_IM_HW];
  assign unused_status = ^{bus.cp0_status_i[31:23], bus.cp0_status_i[21:16],
                           bus.cp0_status_i[SR_IM_HW-1:SR_IM_LO], bus.cp0_status_i[7:2]};

  // Two-flop synchroniser for the asynchronous interrupt lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_meta <= '0;
      int_sync <= '0;
    end else begin
      int_meta <= bus.interrupt_i;
      int_sync <= int_meta;
    end
  end

  assign int_pend = (|(int_sync & sr_im_hw)) & sr_ie & ~sr_exl;

  assign flags = '{
    adel_if:     bus.exc_adel_if_i,
    tlbl_refill: bus.exc_tlbl_refill_i,
    tlbl_inv:    bus.exc_tlbl_inv_i,
    ri:          bus.exc_ri_i,
    sys:         bus.exc_sys_i,
    bp:          bus.exc_bp_i,
    ov:          bus.exc_ov_i,
    adel:        bus.exc_adel_i,
    ades:        bus.exc_ades_i,
    tlbs_refill: bus.exc_tlbs_refill_i,
    tlbs_inv:    bus.exc_tlbs_inv_i,
    tlb_mod:     bus.exc_tlb_mod_i
  };

  exc_prio_enc u_prio (
    .int_pend       (int_pend),
    .flags          (flags),
    .any            (enc_any),
    .exccode        (enc_code),
    .badvaddr_valid (enc_bv_valid),
    .is_refill      (enc_refill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      out_q   <= out_d;
    end
  end

  // Next state, capture, and next-cycle outputs (registered from state_d/cap_d).
  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    out_d   = '0;

    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid_i && enc_any) begin
          state_d              = ST_COMMIT;
          cap_d.exccode        = enc_code;
          cap_d.epc            = sr_exl ? bus.cp0_epc_i
                               : (bus.mem_bd_i ? bus.mem_pc_i - XLEN'(4) : bus.mem_pc_i);
          cap_d.bd             = bus.mem_bd_i;
          cap_d.badvaddr       = bus.bad_vaddr_i;
          cap_d.badvaddr_valid = enc_bv_valid;
          cap_d.target         = vector_target(sr_bev, enc_refill & ~sr_exl);
        end else if (bus.mem_valid_i && bus.eret_i) begin
          state_d      = ST_ERET_WAIT;
          cap_d.target = bus.cp0_epc_i;
        end
      end
      ST_COMMIT:    state_d = ST_REDIRECT;
      ST_REDIRECT,
      ST_ERET_WAIT: if (bus.redirect_ready_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase

    out_d.stall = (state_d != ST_IDLE);

    if (state_d == ST_COMMIT) begin
      out_d.cp0_we          = 1'b1;
      out_d.flush           = 1'b1;
      out_d.cp0_exl_set     = 1'b1;
      out_d.cp0_epc         = cap_d.epc;
      out_d.cp0_exccode     = cap_d.exccode;
      out_d.cp0_bd          = cap_d.bd;
      out_d.cp0_badvaddr_we = cap_d.badvaddr_valid;
      out_d.cp0_badvaddr    = cap_d.badvaddr_valid ? cap_d.badvaddr : '0;
    end

    if (state_d == ST_REDIRECT || state_d == ST_ERET_WAIT) begin
      out_d.redirect_valid = 1'b1;
      out_d.redirect_pc    = cap_d.target;
    end

    // ERET entry cycle: kill younger instructions and drop EXL once.
    if (state_q == ST_IDLE && state_d == ST_ERET_WAIT) begin
      out_d.flush       = 1'b1;
      out_d.cp0_exl_clr = 1'b1;
    end
  end

  assign bus.stall_o           = out_q.stall;
  assign bus.flush_o           = out_q.flush;
  assign bus.redirect_valid_o  = out_q.redirect_valid;
  assign bus.redirect_pc_o     = out_q.redirect_pc;
  assign bus.cp0_we_o          = out_q.cp0_we;
  assign bus.cp0_epc_o         = out_q.cp0_epc;
  assign bus.cp0_exccode_o     = out_q.cp0_exccode;
  assign bus.cp0_bd_o          = out_q.cp0_bd;
  assign bus.cp0_badvaddr_we_o = out_q.cp0_badvaddr_we;
  assign bus.cp0_badvaddr_o    = out_q.cp0_badvaddr;
  assign bus.cp0_exl_set_o     = out_q.cp0_exl_set;
  assign bus.cp0_exl_clr_o     = out_q.cp0_exl_clr;

endmodule

// File: tb/tb_exc_sequencer.sv
// Directed self-checking bench for exc_sequencer: exception commit/redirect,
// interrupt synchronisation and masking, ERET, and mid-sequence reset.
module tb_exc_sequencer;
  import exc_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  exc_sequencer_if bus ();

  exc_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [31:0] SR_BEV_M = 32'h0040_0000;
  localparam logic [31:0] SR_EXL_M = 32'h0000_0002;

  function automatic logic [108:0] all_outs();
    return {bus.stall_o, bus.flush_o, bus.redirect_valid_o, bus.redirect_pc_o,
            bus.cp0_we_o, bus.cp0_epc_o, bus.cp0_exccode_o, bus.cp0_bd_o,
            bus.cp0_badvaddr_we_o, bus.cp0_badvaddr_o, bus.cp0_exl_set_o, bus.cp0_exl_clr_o};
  endfunction

  task automatic set_flags(input exc_flags_t f);
    bus.exc_adel_if_i     = f.adel_if;
    bus.exc_tlbl_refill_i = f.tlbl_refill;
    bus.exc_tlbl_inv_i    = f.tlbl_inv;
    bus.exc_ri_i          = f.ri;
    bus.exc_sys_i         = f.sys;
    bus.exc_bp_i          = f.bp;
    bus.exc_ov_i          = f.ov;
    bus.exc_adel_i        = f.adel;
    bus.exc_ades_i        = f.ades;
    bus.exc_tlbs_refill_i = f.tlbs_refill;
    bus.exc_tlbs_inv_i    = f.tlbs_inv;
    bus.exc_tlb_mod_i     = f.tlb_mod;
  endtask

  task automatic clear_inputs();
    set_flags('0);
    bus.mem_valid_i      = 1'b0;
    bus.mem_pc_i         = '0;
    bus.mem_bd_i         = 1'b0;
    bus.interrupt_i      = '0;
    bus.eret_i           = 1'b0;
    bus.bad_vaddr_i      = '0;
    bus.cp0_status_i     = '0;
    bus.cp0_epc_i        = '0;
    bus.redirect_ready_i = 1'b1;
  endtask

  // Present one MEM-stage instruction for a single edge, then withdraw it.
  task automatic fire(input logic [31:0] pc, input logic bd, input logic [31:0] status,
                      input logic [31:0] bva, input logic [31:0] epc,
                      input exc_flags_t f, input logic eret);
    @(negedge clk);
    bus.mem_valid_i  = 1'b1;
    bus.mem_pc_i     = pc;
    bus.mem_bd_i     = bd;
    bus.cp0_status_i = status;
    bus.bad_vaddr_i  = bva;
    bus.cp0_epc_i    = epc;
    bus.eret_i       = eret;
    set_flags(f);
    @(posedge clk); #1;
    set_flags('0);
    bus.mem_valid_i = 1'b0;
    bus.eret_i      = 1'b0;
  endtask

  task automatic test_reset();
    logic [108:0] v;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    v = all_outs();
    checks++; if (v !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", v); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL reset_idle_stall: got %b expected 0", bus.stall_o); end
  endtask

  task automatic test_ov();
    exc_flags_t f;
    f = '0; f.ov = 1'b1;
    fire(32'h8000_1000, 1'b0, 32'h0, 32'hDEAD_0000, 32'h0, f, 1'b0);
    checks++; if (bus.cp0_exccode_o !== 5'd12) begin errors++; $display("FAIL ov_exccode: got %0d expected 12", bus.cp0_exccode_o); end
    checks++; if (bus.cp0_epc_o !== 32'h8000_1000) begin errors++; $display("FAIL ov_epc: got %h expected 80001000", bus.cp0_epc_o); end
    checks++; if ({bus.cp0_we_o, bus.flush_o, bus.cp0_exl_set_o, bus.cp0_badvaddr_we_o, bus.stall_o, bus.redirect_valid_o} !== 6'b111010)
      begin errors++; $display("FAIL ov_commit_strobes: got %b expected 111010",
        {bus.cp0_we_o, bus.flush_o, bus.cp0_exl_set_o, bus.cp0_badvaddr_we_o, bus.stall_o, bus.redirect_valid_o}); end
    @(posedge clk); #1;
    checks++; if ({bus.flush_o, bus.cp0_exl_set_o, bus.cp0_we_o, bus.redirect_valid_o, bus.stall_o} !== 5'b00011)
      begin errors++; $display("FAIL ov_redirect_strobes: got %b expected 00011",
        {bus.flush_o, bus.cp0_exl_set_o, bus.cp0_we_o, bus.redirect_valid_o, bus.stall_o}); end
    checks++; if (bus.redirect_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL ov_target: got %h expected 80000180", bus.redirect_pc_o); end
    @(posedge clk); #1;
    checks++; if ({bus.stall_o, bus.redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL ov_back_idle: got %b expected 00", {bus.stall_o, bus.redirect_valid_o}); end
  endtask

  task automatic test_tlbl_refill_bd();
    exc_flags_t f;
    f = '0; f.tlbl_refill = 1'b1;
    fire(32'h8000_2004, 1'b1, SR_BEV_M, 32'h0040_0000, 32'h0, f, 1'b0);
    checks++; if (bus.cp0_exccode_o !== 5'd2) begin errors++; $display("FAIL refill_bd_exccode: got %0d expected 2", bus.cp0_exccode_o); end
    checks++; if (bus.cp0_epc_o !== 32'h8000_2000) begin errors++; $display("FAIL refill_bd_epc: got %h expected 80002000", bus.cp0_epc_o); end
    checks++; if ({bus.cp0_bd_o, bus.cp0_badvaddr_we_o} !== 2'b11) begin errors++; $display("FAIL refill_bd_bd_bvwe: got %b expected 11", {bus.cp0_bd_o, bus.cp0_badvaddr_we_o}); end
    checks++; if (bus.cp0_badvaddr_o !== 32'h0040_0000) begin errors++; $display("FAIL refill_bd_badvaddr: got %h expected 00400000", bus.cp0_badvaddr_o); end
    @(posedge clk); #1;
    checks++; if (bus.redirect_pc_o !== 32'hBFC0_0200) begin errors++; $display("FAIL refill_bd_target: got %h expected bfc00200", bus.redirect_pc_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_refill_exl();
    exc_flags_t f;
    f = '0; f.tlbl_refill = 1'b1;
    fire(32'h8000_4000, 1'b0, SR_EXL_M, 32'h0040_1000, 32'h8000_5555, f, 1'b0);
    checks++; if ({bus.cp0_we_o, bus.cp0_exl_set_o} !== 2'b11) begin errors++; $display("FAIL refill_exl_we: got %b expected 11", {bus.cp0_we_o, bus.cp0_exl_set_o}); end
    checks++; if (bus.cp0_epc_o !== 32'h8000_5555) begin errors++; $display("FAIL refill_exl_epc_kept: got %h expected 80005555", bus.cp0_epc_o); end
    @(posedge clk); #1;
    checks++; if (bus.redirect_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL refill_exl_target: got %h expected 80000180", bus.redirect_pc_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_interrupt();
    @(negedge clk);
    bus.cp0_status_i = 32'h0000_FF01;
    bus.interrupt_i  = 6'b000100;
    bus.mem_valid_i  = 1'b1;
    bus.mem_pc_i     = 32'h8000_6000;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.stall_o !== 1'b0) begin errors++; $display("FAIL int_sync_delay%0d: got %b expected 0", i, bus.stall_o); end
    end
    @(posedge clk); #1;
    bus.mem_valid_i = 1'b0;
    bus.interrupt_i = '0;
    checks++; if ({bus.stall_o, bus.cp0_we_o} !== 2'b11) begin errors++; $display("FAIL int_taken: got %b expected 11", {bus.stall_o, bus.cp0_we_o}); end
    checks++; if (bus.cp0_exccode_o !== 5'd0) begin errors++; $display("FAIL int_exccode: got %0d expected 0", bus.cp0_exccode_o); end
    checks++; if (bus.cp0_epc_o !== 32'h8000_6000) begin errors++; $display("FAIL int_epc: got %h expected 80006000", bus.cp0_epc_o); end
    @(posedge clk); #1;
    checks++; if (bus.redirect_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL int_target: got %h expected 80000180", bus.redirect_pc_o); end
    bus.cp0_status_i = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_interrupt_masked();
    @(negedge clk);
    bus.cp0_status_i = 32'h0000_FF00;
    bus.interrupt_i  = 6'b000100;
    bus.mem_valid_i  = 1'b1;
    bus.mem_pc_i     = 32'h8000_6100;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.stall_o, bus.cp0_we_o} !== 2'b00) begin errors++; $display("FAIL int_masked%0d: got %b expected 00", i, {bus.stall_o, bus.cp0_we_o}); end
    end
    bus.mem_valid_i  = 1'b0;
    bus.interrupt_i  = '0;
    bus.cp0_status_i = '0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_eret_vs_ov();
    exc_flags_t f;
    f = '0; f.ov = 1'b1;
    fire(32'h8000_7000, 1'b0, 32'h0, 32'h0, 32'h8000_3000, f, 1'b1);
    checks++; if ({bus.cp0_we_o, bus.cp0_exl_set_o, bus.cp0_exl_clr_o} !== 3'b110) begin errors++; $display("FAIL eret_ov_strobes: got %b expected 110", {bus.cp0_we_o, bus.cp0_exl_set_o, bus.cp0_exl_clr_o}); end
    checks++; if (bus.cp0_exccode_o !== 5'd12) begin errors++; $display("FAIL eret_ov_exccode: got %0d expected 12", bus.cp0_exccode_o); end
    @(posedge clk); #1;
    checks++; if (bus.redirect_pc_o !== 32'h8000_0180) begin errors++; $display("FAIL eret_ov_target: got %h expected 80000180", bus.redirect_pc_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_eret();
    bus.redirect_ready_i = 1'b0;
    fire(32'h8000_8000, 1'b0, SR_EXL_M, 32'h0, 32'h8000_3000, '0, 1'b1);
    bus.cp0_epc_i = 32'h1234_5678;
    checks++; if ({bus.flush_o, bus.cp0_exl_clr_o, bus.cp0_we_o, bus.stall_o, bus.redirect_valid_o} !== 5'b11011)
      begin errors++; $display("FAIL eret_entry: got %b expected 11011",
        {bus.flush_o, bus.cp0_exl_clr_o, bus.cp0_we_o, bus.stall_o, bus.redirect_valid_o}); end
    checks++; if (bus.redirect_pc_o !== 32'h8000_3000) begin errors++; $display("FAIL eret_target: got %h expected 80003000", bus.redirect_pc_o); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.redirect_valid_o, bus.flush_o, bus.cp0_exl_clr_o, bus.stall_o} !== 4'b1001 || bus.redirect_pc_o !== 32'h8000_3000)
        begin errors++; $display("FAIL eret_hold%0d: got %b pc %h expected 1001 pc 80003000", i,
          {bus.redirect_valid_o, bus.flush_o, bus.cp0_exl_clr_o, bus.stall_o}, bus.redirect_pc_o); end
    end
    bus.redirect_ready_i = 1'b1;
    @(posedge clk); #1;
    checks++; if ({bus.stall_o, bus.redirect_valid_o} !== 2'b00) begin errors++; $display("FAIL eret_release: got %b expected 00", {bus.stall_o, bus.redirect_valid_o}); end
    bus.cp0_status_i = '0;
    bus.cp0_epc_i    = '0;
  endtask

  task automatic test_reset_mid();
    exc_flags_t   f;
    logic [108:0] v;
    f = '0; f.ov = 1'b1;
    bus.redirect_ready_i = 1'b0;
    fire(32'h8000_9000, 1'b0, 32'h0, 32'h0, 32'h0, f, 1'b0);
    @(posedge clk); #1;
    checks++; if (bus.redirect_valid_o !== 1'b1) begin errors++; $display("FAIL rstmid_in_redirect: got %b expected 1", bus.redirect_valid_o); end
    #2 rst_n = 1'b0;
    #1;
    v = all_outs();
    checks++; if (v !== '0) begin errors++; $display("FAIL rstmid_async_clear: got %h expected 0", v); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.redirect_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.stall_o, bus.cp0_we_o, bus.redirect_valid_o} !== 3'b000) begin errors++; $display("FAIL rstmid_after%0d: got %b expected 000", i, {bus.stall_o, bus.cp0_we_o, bus.redirect_valid_o}); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_ov();
    test_tlbl_refill_bd();
    test_refill_exl();
    test_interrupt();
    test_interrupt_masked();
    test_eret_vs_ov();
    test_eret();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
